// File: rtl/spi_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_req_arbiter
// Brief    : Round-robin sharing of one SPI master among NREQ requesters,
//            with a watchdog that releases the bus on a stuck master.
// Revision : 1.0
// ============================================================================
module spi_req_arbiter #(
    parameter int NREQ      = 4,
    parameter int REG_WIDTH = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                      sys_clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*REG_WIDTH-1:0] tx_data,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    output logic                      err,
    output logic [REG_WIDTH-1:0]      rx_data,
    output logic                      busy,
    output logic                      m_start,
    output logic [REG_WIDTH-1:0]      m_tx,
    input  logic                      m_done,
    input  logic [REG_WIDTH-1:0]      m_rx
);

    localparam int c_IDX_W = $clog2(NREQ);
    localparam int c_WDG_W = $clog2(TIMEOUT);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NREQ - 1);
    localparam logic [c_WDG_W-1:0] c_WDG_ONE  = c_WDG_W'(1);
    localparam logic [c_WDG_W-1:0] c_WDG_LAST = c_WDG_W'(TIMEOUT - 1);
    localparam logic [NREQ-1:0]    c_GNT_ONE  = NREQ'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    logic [c_IDX_W-1:0]     r_last;
    logic [c_WDG_W-1:0]     r_wdog;
    logic [NREQ-1:0]        r_gnt;
    logic [NREQ-1:0]        r_done;
    logic                   r_err;
    logic                   r_busy;
    logic                   r_m_start;
    logic [REG_WIDTH-1:0]   r_m_tx;
    logic [REG_WIDTH-1:0]   r_rx_data;

    logic                   w_found;
    logic [c_IDX_W-1:0]     w_winner;
    logic [REG_WIDTH-1:0]   w_tx;

    function automatic int wrap_idx(input logic [c_IDX_W-1:0] base, input int step);
        return (int'(base) + step) % NREQ;
    endfunction

    // Search starts just after the previous winner, so the last winner has lowest priority.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last;
        w_tx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req[wrap_idx(r_last, k)]) begin
                w_found  = 1'b1;
                w_winner = c_IDX_W'(wrap_idx(r_last, k));
                w_tx     = tx_data[wrap_idx(r_last, k)*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_last    <= c_LAST_RST;
            r_wdog    <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_m_start <= 1'b0;
            r_m_tx    <= '0;
            r_rx_data <= '0;
        end else begin
            r_done    <= '0;
            r_err     <= 1'b0;
            r_m_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_gnt   <= c_GNT_ONE << w_winner;
                        r_last  <= w_winner;
                        r_m_tx  <= w_tx;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_m_start <= 1'b1;
                    r_wdog    <= '0;
                    r_state   <= S_START;
                end
                // The watchdog counts cycles since the start strobe, START included.
                S_START: begin
                    r_wdog  <= c_WDG_ONE;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (m_done) begin
                        r_rx_data <= m_rx;
                        r_done    <= r_gnt;
                        r_gnt     <= '0;
                        r_state   <= S_DONE;
                    end else if (r_wdog == c_WDG_LAST) begin
                        r_err   <= 1'b1;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + c_WDG_ONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign err     = r_err;
    assign busy    = r_busy;
    assign m_start = r_m_start;
    assign m_tx    = r_m_tx;
    assign rx_data = r_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_req_arbiter
// Brief    : Scenario bench for spi_req_arbiter against a round-robin model.
// Revision : 1.0
// ============================================================================
module tb_spi_req_arbiter;

    localparam int NREQ = 4;
    localparam int RW   = 8;
    localparam int TO   = 64;

    logic              sys_clk = 1'b0;
    logic              rstn    = 1'b0;
    logic [NREQ-1:0]   req     = '0;
    logic [NREQ*RW-1:0] tx_data = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              err;
    logic [RW-1:0]     rx_data;
    logic              busy;
    logic              m_start;
    logic [RW-1:0]     m_tx;
    logic              m_done  = 1'b0;
    logic [RW-1:0]     m_rx    = '0;

    int cyc        = 0;
    int n_cmp      = 0;
    int n_bad      = 0;
    int n_mstart   = 0;
    int model_last = NREQ - 1;

    spi_req_arbiter #(.NREQ(NREQ), .REG_WIDTH(RW), .TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .rstn(rstn), .req(req), .tx_data(tx_data),
        .gnt(gnt), .done(done), .err(err), .rx_data(rx_data), .busy(busy),
        .m_start(m_start), .m_tx(m_tx), .m_done(m_done), .m_rx(m_rx)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;
    always @(negedge sys_clk) if (m_start === 1'b1) n_mstart <= n_mstart + 1;

    // Reference arbitration: first requesting index after the last winner, modulo NREQ.
    function automatic int pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge sys_clk);
        rstn = 1'b0; req = '0; m_done = 1'b0;
        #2;
        rstn = 1'b1;
        model_last = NREQ - 1;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge sys_clk);
            if (gnt !== '0) ok = 1'b1;
        end
    endtask

    task automatic wait_mstart(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge sys_clk);
            if (m_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge sys_clk);
            if (done !== '0) ok = 1'b1;
        end
    endtask

    // Plays the SPI master: answers d cycles after the current point.
    task automatic master_echo(input int d, input logic [RW-1:0] b, output int t_md);
        repeat (d) tick;
        m_done = 1'b1; m_rx = b; t_md = cyc;
        tick;
        m_done = 1'b0; m_rx = RW'($urandom);
    endtask

    task automatic test_reset;
        @(negedge sys_clk);
        n_cmp++;
        if ({gnt, done, err, busy, m_start} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl: gnt=%b done=%b err=%b busy=%b m_start=%b, expected all 0", gnt, done, err, busy, m_start);
        end
        n_cmp++;
        if (rx_data !== '0 || m_tx !== '0) begin
            n_bad++;
            $display("FAIL reset_data: rx_data=%h m_tx=%h, expected 00 00", rx_data, m_tx);
        end
        #2 rstn = 1'b1;
        tick;
        @(negedge sys_clk);
        n_cmp++;
        if (busy !== 1'b0 || gnt !== '0) begin
            n_bad++;
            $display("FAIL idle_no_req: busy=%b gnt=%b, expected 0 0000", busy, gnt);
        end
    endtask

    task automatic test_single;
        bit ok; int t_req, t_md;
        tx_data = '0; tx_data[7:0] = 8'hA5;
        tick;
        req = 4'b0001; t_req = cyc;
        model_last = pick(req, model_last);
        wait_gnt(ok);
        n_cmp++;
        if (!ok || gnt !== 4'b0001 || cyc - t_req != 1) begin
            n_bad++;
            $display("FAIL single_gnt: gnt=%b at +%0d, expected 0001 at +1", gnt, cyc - t_req);
        end
        wait_mstart(ok);
        n_cmp++;
        if (!ok || cyc - t_req != 2 || m_tx !== 8'hA5) begin
            n_bad++;
            $display("FAIL single_start: m_start at +%0d m_tx=%h, expected +2 A5", cyc - t_req, m_tx);
        end
        req = '0;
        master_echo(10, 8'hA5, t_md);
        wait_done(ok);
        n_cmp++;
        if (!ok || done !== 4'b0001 || cyc - t_md != 1 || rx_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL single_done: done=%b lat=%0d rx=%h, expected 0001 1 A5", done, cyc - t_md, rx_data);
        end
        @(negedge sys_clk);
        n_cmp++;
        if (done !== '0 || busy !== 1'b0 || rx_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL single_after: done=%b busy=%b rx=%h, expected 0000 0 A5", done, busy, rx_data);
        end
    endtask

    task automatic test_round_robin;
        bit ok; int w, t_md, n0; logic [RW-1:0] b;
        do_reset;
        n0 = n_mstart;
        tick;
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tx_data = {$urandom};
            w = pick(req, model_last);
            model_last = w;
            wait_gnt(ok);
            n_cmp++;
            if (!ok || gnt !== onehot(w) || gnt !== onehot(i % NREQ)) begin
                n_bad++;
                $display("FAIL rr_gnt[%0d]: gnt=%b, expected %b", i, gnt, onehot(i % NREQ));
            end
            wait_mstart(ok);
            n_cmp++;
            if (!ok || m_tx !== tx_data[w*RW +: RW]) begin
                n_bad++;
                $display("FAIL rr_mtx[%0d]: m_tx=%h, expected %h", i, m_tx, tx_data[w*RW +: RW]);
            end
            b = RW'($urandom_range(1, 255));
            master_echo($urandom_range(1, 6), b, t_md);
            wait_done(ok);
            if (i == 7) req = '0;
            n_cmp++;
            if (!ok || done !== onehot(w) || rx_data !== b) begin
                n_bad++;
                $display("FAIL rr_done[%0d]: done=%b rx=%h, expected %b %h", i, done, rx_data, onehot(w), b);
            end
        end
        tick;
        n_cmp++;
        if (n_mstart - n0 != 8) begin
            n_bad++;
            $display("FAIL rr_mstart_count: got %0d, expected 8", n_mstart - n0);
        end
    endtask

    task automatic test_wrap;
        logic [NREQ-1:0] reqs [5];
        int exps [5];
        bit ok; int t_md;
        reqs = '{4'b0100, 4'b0011, 4'b0011, 4'b1000, 4'b1001};
        exps = '{2, 0, 1, 3, 0};
        do_reset;
        for (int i = 0; i < 5; i++) begin
            tick;
            req = reqs[i];
            wait_gnt(ok);
            n_cmp++;
            if (!ok || gnt !== onehot(exps[i]) || pick(reqs[i], model_last) != exps[i]) begin
                n_bad++;
                $display("FAIL wrap_gnt[%0d]: gnt=%b, expected %b", i, gnt, onehot(exps[i]));
            end
            model_last = exps[i];
            wait_mstart(ok);
            master_echo(2, 8'h5A + 8'(i), t_md);
            wait_done(ok);
            req = '0;
            n_cmp++;
            if (!ok || done !== onehot(exps[i])) begin
                n_bad++;
                $display("FAIL wrap_done[%0d]: done=%b, expected %b", i, done, onehot(exps[i]));
            end
        end
    endtask

    task automatic test_timeout;
        bit ok, saw_done, saw_err; int w, t_st; logic [RW-1:0] rx_before;
        rx_before = rx_data;
        tick;
        req = 4'b0001;
        w = pick(req, model_last);
        model_last = w;
        wait_gnt(ok);
        wait_mstart(ok);
        t_st = cyc;
        req = '0;
        saw_done = 1'b0; saw_err = 1'b0;
        for (int k = 0; k < 100 && !saw_err; k++) begin
            @(negedge sys_clk);
            if (done !== '0) saw_done = 1'b1;
            if (err === 1'b1) saw_err = 1'b1;
        end
        n_cmp++;
        if (!ok || !saw_err || cyc - t_st != TO || saw_done) begin
            n_bad++;
            $display("FAIL timeout_err: err at +%0d seen=%b done_seen=%b, expected +%0d 1 0", cyc - t_st, saw_err, saw_done, TO);
        end
        n_cmp++;
        if (gnt !== '0 || busy !== 1'b0 || rx_data !== rx_before) begin
            n_bad++;
            $display("FAIL timeout_state: gnt=%b busy=%b rx=%h, expected 0000 0 %h", gnt, busy, rx_data, rx_before);
        end
        @(negedge sys_clk);
        n_cmp++;
        if (err !== 1'b0 || done !== '0) begin
            n_bad++;
            $display("FAIL timeout_pulse: err=%b done=%b, expected 0 0000", err, done);
        end
    endtask

    task automatic test_reset_mid;
        bit ok; int t_req, t_md;
        tick;
        req = 4'b0010;
        wait_gnt(ok);
        wait_mstart(ok);
        repeat (3) tick;
        #2 rstn = 1'b0;
        req = '0;
        #1;
        n_cmp++;
        if ({gnt, done, err, busy, m_start} !== '0 || rx_data !== '0 || m_tx !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: gnt=%b done=%b err=%b busy=%b rx=%h m_tx=%h, expected all 0", gnt, done, err, busy, rx_data, m_tx);
        end
        @(negedge sys_clk);
        #1 rstn = 1'b1;
        model_last = NREQ - 1;
        tx_data = '0; tx_data[23:16] = 8'h96;
        tick;
        req = 4'b0100; t_req = cyc;
        wait_gnt(ok);
        n_cmp++;
        if (!ok || gnt !== 4'b0100 || cyc - t_req != 1) begin
            n_bad++;
            $display("FAIL reset_mid_gnt: gnt=%b at +%0d, expected 0100 at +1", gnt, cyc - t_req);
        end
        model_last = 2;
        wait_mstart(ok);
        master_echo(3, 8'h69, t_md);
        wait_done(ok);
        req = '0;
        n_cmp++;
        if (!ok || done !== 4'b0100 || rx_data !== 8'h69 || m_tx !== 8'h96) begin
            n_bad++;
            $display("FAIL reset_mid_done: done=%b rx=%h m_tx=%h, expected 0100 69 96", done, rx_data, m_tx);
        end
    endtask

    task automatic test_stray;
        bit ok; int t_md;
        tick;
        req = 4'b0010;
        model_last = pick(req, model_last);
        wait_gnt(ok);
        m_done = 1'b1; m_rx = 8'h3C;
        @(negedge sys_clk);
        m_done = 1'b0;
        n_cmp++;
        if (m_start !== 1'b1 || done !== '0 || gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL stray_ignored: m_start=%b done=%b gnt=%b, expected 1 0000 0010", m_start, done, gnt);
        end
        tick;
        req = '0;
        master_echo(4, 8'hC3, t_md);
        wait_done(ok);
        n_cmp++;
        if (!ok || done !== 4'b0010 || cyc - t_md != 1 || rx_data !== 8'hC3) begin
            n_bad++;
            $display("FAIL stray_done: done=%b lat=%0d rx=%h, expected 0010 1 C3", done, cyc - t_md, rx_data);
        end
    endtask

    task automatic test_random;
        bit ok; int w, t_req, t_gnt, t_md; logic [RW-1:0] b, exp_tx;
        for (int i = 0; i < 20; i++) begin
            tx_data = {$urandom};
            tick;
            req = NREQ'($urandom_range(1, 15)); t_req = cyc;
            w = pick(req, model_last);
            model_last = w;
            exp_tx = tx_data[w*RW +: RW];
            wait_gnt(ok);
            t_gnt = cyc;
            n_cmp++;
            if (!ok || gnt !== onehot(w) || t_gnt - t_req != 1) begin
                n_bad++;
                $display("FAIL rnd_gnt[%0d]: req=%b gnt=%b at +%0d, expected %b at +1", i, req, gnt, t_gnt - t_req, onehot(w));
            end
            tx_data = {$urandom};
            wait_mstart(ok);
            n_cmp++;
            if (!ok || cyc - t_gnt != 1 || m_tx !== exp_tx) begin
                n_bad++;
                $display("FAIL rnd_start[%0d]: m_tx=%h at +%0d, expected %h at +1", i, m_tx, cyc - t_gnt, exp_tx);
            end
            if ($urandom_range(0, 1) == 1) req = '0;
            b = RW'($urandom);
            master_echo($urandom_range(1, 20), b, t_md);
            wait_done(ok);
            req = '0;
            n_cmp++;
            if (!ok || done !== onehot(w) || cyc - t_md != 1) begin
                n_bad++;
                $display("FAIL rnd_done[%0d]: done=%b lat=%0d, expected %b 1", i, done, cyc - t_md, onehot(w));
            end
            n_cmp++;
            if (rx_data !== b) begin
                n_bad++;
                $display("FAIL rnd_rx[%0d]: rx_data=%h, expected %h", i, rx_data, b);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_wrap;
        test_timeout;
        test_reset_mid;
        test_stray;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
